// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-ROM arbiter.
// addr_ok decides whether a word access fits entirely inside the ROM window.
package imem_pkg;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } requester_e;

  localparam logic [31:0] DEFAULT_ROM_BASE = 32'hBFC00000;
  localparam logic [31:0] DEFAULT_ROM_TOP  = 32'hBFC00FFF;

  // The end address is computed one bit wider so addresses near 2^32 cannot wrap into range.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] top);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'd3;
    return (addr >= base) && (last_byte <= {1'b0, top}) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/resp_slot.sv
// One-entry ready/valid response register.
// A load wins over a drain, so a slot drained and granted in the same cycle refills.
module resp_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_err,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             err
);

  // NOTE: data and err are reset too because they are visible on the ports from reset on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      err   <= load_err;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one asynchronous-read instruction ROM between
// the fetch requester and the data-side constant-load requester.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int                         ADDRESS_WIDTH     = 32,
  parameter int                         INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   ROM_BASE          = ADDRESS_WIDTH'(DEFAULT_ROM_BASE),
  parameter logic [ADDRESS_WIDTH-1:0]   ROM_TOP           = ADDRESS_WIDTH'(DEFAULT_ROM_TOP)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         f_req,
  input  logic [ADDRESS_WIDTH-1:0]     f_addr,
  output logic                         f_gnt,
  output logic                         f_rvalid,
  output logic [INSTRUCTION_WIDTH-1:0] f_rdata,
  output logic                         f_err,
  input  logic                         f_rready,
  input  logic                         d_req,
  input  logic [ADDRESS_WIDTH-1:0]     d_addr,
  output logic                         d_gnt,
  output logic                         d_rvalid,
  output logic [INSTRUCTION_WIDTH-1:0] d_rdata,
  output logic                         d_err,
  input  logic                         d_rready,
  output logic [ADDRESS_WIDTH-1:0]     mem_a,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_rd
);

  requester_e                   last_grant;
  logic                         f_elig;
  logic                         d_elig;
  logic                         access_ok;
  logic [INSTRUCTION_WIDTH-1:0] load_data;

  // A slot being drained this cycle counts as free, so it can be refilled without a bubble.
  assign f_elig = f_req && (!f_rvalid || f_rready);
  assign d_elig = d_req && (!d_rvalid || d_rready);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (f_elig && d_elig) begin
      if (last_grant == REQ_FETCH) d_gnt = 1'b1;
      else                         f_gnt = 1'b1;
    end else if (f_elig) begin
      f_gnt = 1'b1;
    end else if (d_elig) begin
      d_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_a = ROM_BASE;
    if (f_gnt)      mem_a = f_addr;
    else if (d_gnt) mem_a = d_addr;
  end

  assign access_ok = addr_ok(32'(mem_a), 32'(ROM_BASE), 32'(ROM_TOP));
  assign load_data = access_ok ? mem_rd : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant <= REQ_DATA;
    else if (f_gnt) last_grant <= REQ_FETCH;
    else if (d_gnt) last_grant <= REQ_DATA;
  end

  resp_slot #(.WIDTH(INSTRUCTION_WIDTH)) u_f_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (f_gnt),
    .load_data(load_data),
    .load_err (!access_ok),
    .drain    (f_rready),
    .valid    (f_rvalid),
    .data     (f_rdata),
    .err      (f_err)
  );

  resp_slot #(.WIDTH(INSTRUCTION_WIDTH)) u_d_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (d_gnt),
    .load_data(load_data),
    .load_err (!access_ok),
    .drain    (d_rready),
    .valid    (d_rvalid),
    .data     (d_rdata),
    .err      (d_err)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Scenario bench for imem_arbiter: a byte ROM model feeds mem_rd, and expected
// responses are queued per requester at grant time and compared when the slot shows them.
module tb_imem_arbiter;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam logic [31:0] TOP  = 32'hBFC00FFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0, f_rready = 1'b0, d_req = 1'b0, d_rready = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0;
  logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err;
  logic [31:0] f_rdata, d_rdata, mem_a, mem_rd;

  logic [7:0]  rom [4096];
  logic [32:0] fq[$];
  logic [32:0] dq[$];
  int          checks = 0;
  int          failures = 0;

  imem_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_gnt   (f_gnt),
    .f_rvalid(f_rvalid),
    .f_rdata (f_rdata),
    .f_err   (f_err),
    .f_rready(f_rready),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .d_err   (d_err),
    .d_rready(d_rready),
    .mem_a   (mem_a),
    .mem_rd  (mem_rd)
  );

  always #5 clk = ~clk;

  // Asynchronous ROM: little-endian word assembled from the low 12 address bits.
  assign mem_rd = {rom[mem_a[11:0] + 12'd3], rom[mem_a[11:0] + 12'd2],
                   rom[mem_a[11:0] + 12'd1], rom[mem_a[11:0]]};

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [11:0] o;
    o = a[11:0];
    return {rom[o + 12'd3], rom[o + 12'd2], rom[o + 12'd1], rom[o]};
  endfunction

  function automatic logic [32:0] expect_resp(input logic [31:0] a);
    logic bad;
    bad = (a < BASE) || (({1'b0, a} + 33'd3) > {1'b0, TOP}) || (a[1:0] != 2'b00);
    return bad ? {1'b1, 32'h0} : {1'b0, rom_word(a)};
  endfunction

  task automatic drive(input logic fr, input logic [31:0] fa, input logic frr,
                       input logic dr, input logic [31:0] da, input logic drr);
    f_req = fr; f_addr = fa; f_rready = frr;
    d_req = dr; d_addr = da; d_rready = drr;
  endtask

  // Updates the scoreboard for the coming edge, then moves to just after it.
  task automatic advance(input logic gf, input logic gd);
    if (fq.size() != 0 && f_rready) void'(fq.pop_front());
    if (dq.size() != 0 && d_rready) void'(dq.pop_front());
    if (gf) fq.push_back(expect_resp(f_addr));
    if (gd) dq.push_back(expect_resp(d_addr));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    fq.delete();
    dq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({f_rvalid, d_rvalid} !== 2'b00) begin
      failures++; $display("FAIL reset_rvalid got=%b expected=00", {f_rvalid, d_rvalid});
    end
    checks++;
    if ({f_err, f_rdata, d_err, d_rdata} !== 66'h0) begin
      failures++; $display("FAIL reset_data got f=%b/%h d=%b/%h expected 0", f_err, f_rdata, d_err, d_rdata);
    end
    checks++;
    if (mem_a !== BASE) begin
      failures++; $display("FAIL reset_mem_a got=%h expected=%h", mem_a, BASE);
    end
    checks++;
    if ({f_gnt, d_gnt} !== 2'b00) begin
      failures++; $display("FAIL reset_gnt got=%b expected=00", {f_gnt, d_gnt});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    drive(1'b1, BASE, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if ({f_gnt, d_gnt, f_rvalid} !== 3'b100) begin
      failures++; $display("FAIL single_grant got gnt/rvalid=%b expected=100", {f_gnt, d_gnt, f_rvalid});
    end
    checks++;
    if (mem_a !== BASE) begin
      failures++; $display("FAIL single_mem_a got=%h expected=%h", mem_a, BASE);
    end
    advance(1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if ({f_rvalid, f_err, f_rdata} !== {2'b10, 32'h00000513} || fq.size() != 1) begin
      failures++; $display("FAIL single_resp got v=%b e=%b d=%h expected v=1 e=0 d=00000513", f_rvalid, f_err, f_rdata);
    end
    checks++;
    if ({f_gnt, d_gnt, d_rvalid} !== 3'b000) begin
      failures++; $display("FAIL single_idle got gnt/d_rvalid=%b expected=000", {f_gnt, d_gnt, d_rvalid});
    end
    advance(1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (f_rvalid !== 1'b0) begin
      failures++; $display("FAIL single_drained got f_rvalid=%b expected=0", f_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic ef;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      ef = (i % 2 == 0);
      if (i < 6) drive(1'b1, BASE + 32'(8 * i), 1'b1, 1'b1, BASE + 32'h100 + 32'(4 * i), 1'b1);
      else       drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (i < 6 && {f_gnt, d_gnt} !== {ef, !ef}) begin
        failures++; $display("FAIL rr_grant cycle=%0d got=%b expected=%b", i, {f_gnt, d_gnt}, {ef, !ef});
      end
      checks++;
      if ({f_rvalid, d_rvalid} !== {fq.size() != 0, dq.size() != 0}) begin
        failures++; $display("FAIL rr_rvalid cycle=%0d got=%b expected=%b", i, {f_rvalid, d_rvalid},
                             {fq.size() != 0, dq.size() != 0});
      end
      if (fq.size() != 0) begin
        checks++;
        if ({f_err, f_rdata} !== fq[0]) begin
          failures++; $display("FAIL rr_f_data cycle=%0d got=%h expected=%h", i, {f_err, f_rdata}, fq[0]);
        end
      end
      if (dq.size() != 0) begin
        checks++;
        if ({d_err, d_rdata} !== dq[0]) begin
          failures++; $display("FAIL rr_d_data cycle=%0d got=%h expected=%h", i, {d_err, d_rdata}, dq[0]);
        end
      end
      advance(i < 6 && ef, i < 6 && !ef);
    end
  endtask

  task automatic test_access_errors();
    logic [31:0] addrs[4];
    logic        errs[4];
    addrs = '{32'hBFC00FFE, 32'hBFC00002, 32'hBFC00FFC, 32'h00001000};
    errs  = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1, addrs[i], 1'b1);
      @(negedge clk);
      checks++;
      if ({f_gnt, d_gnt} !== 2'b01 || mem_a !== addrs[i]) begin
        failures++; $display("FAIL err_grant addr=%h got gnt=%b mem_a=%h expected gnt=01 mem_a=%h",
                             addrs[i], {f_gnt, d_gnt}, mem_a, addrs[i]);
      end
      advance(1'b0, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if ({d_rvalid, d_err, d_rdata} !== {1'b1, errs[i], errs[i] ? 32'h0 : rom_word(addrs[i])}) begin
        failures++; $display("FAIL err_resp addr=%h got v=%b e=%b d=%h expected e=%b", addrs[i],
                             d_rvalid, d_err, d_rdata, errs[i]);
      end
      checks++;
      if ({d_err, d_rdata} !== dq[0] || {f_gnt, f_rvalid, f_err} !== 3'b000) begin
        failures++; $display("FAIL err_side addr=%h got %h f=%b expected %h f=000", addrs[i],
                             {d_err, d_rdata}, {f_gnt, f_rvalid, f_err}, dq[0]);
      end
      advance(1'b0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x0, x2;
    x0 = BASE + 32'h40;
    x2 = BASE + 32'h48;
    drive(1'b1, x0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if ({f_gnt, d_gnt} !== 2'b10) begin
      failures++; $display("FAIL bp_first got=%b expected=10", {f_gnt, d_gnt});
    end
    advance(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BASE + 32'h44, 1'b0, 1'b1, BASE + 32'h200 + 32'(4 * i), 1'b1);
      @(negedge clk);
      checks++;
      if ({f_gnt, d_gnt} !== 2'b01) begin
        failures++; $display("FAIL bp_grant cycle=%0d got=%b expected=01", i, {f_gnt, d_gnt});
      end
      checks++;
      if ({f_rvalid, f_err, f_rdata} !== {2'b10, rom_word(x0)}) begin
        failures++; $display("FAIL bp_hold cycle=%0d got v=%b d=%h expected v=1 d=%h", i, f_rvalid, f_rdata, rom_word(x0));
      end
      checks++;
      if (d_rvalid !== (dq.size() != 0) || (dq.size() != 0 && {d_err, d_rdata} !== dq[0])) begin
        failures++; $display("FAIL bp_data cycle=%0d got v=%b d=%h", i, d_rvalid, d_rdata);
      end
      advance(1'b0, 1'b1);
    end
    drive(1'b1, x2, 1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if ({f_gnt, d_gnt, f_rvalid} !== 3'b101) begin
      failures++; $display("FAIL bp_refill_grant got=%b expected=101", {f_gnt, d_gnt, f_rvalid});
    end
    checks++;
    if ({d_rvalid, d_err, d_rdata} !== {1'b1, dq[0]}) begin
      failures++; $display("FAIL bp_d_last got v=%b d=%h expected %h", d_rvalid, d_rdata, dq[0]);
    end
    advance(1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if ({f_rvalid, f_err, f_rdata} !== {2'b10, rom_word(x2)} || {f_err, f_rdata} !== fq[0]) begin
      failures++; $display("FAIL bp_refill got v=%b d=%h expected v=1 d=%h", f_rvalid, f_rdata, rom_word(x2));
    end
    advance(1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, BASE + 32'h10, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    advance(f_gnt, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, BASE + 32'h20, 1'b0);
    @(negedge clk);
    advance(1'b0, d_gnt);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if ({f_rvalid, d_rvalid} !== 2'b11) begin
      failures++; $display("FAIL ar_filled got=%b expected=11", {f_rvalid, d_rvalid});
    end
    #2;
    rst_n = 1'b0;
    fq.delete();
    dq.delete();
    #1;
    checks++;
    if ({f_rvalid, d_rvalid, f_err, d_err, f_rdata, d_rdata} !== 68'h0) begin
      failures++; $display("FAIL ar_clear got v=%b%b e=%b%b f=%h d=%h expected all 0",
                           f_rvalid, d_rvalid, f_err, d_err, f_rdata, d_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, BASE + 32'h30, 1'b1, 1'b1, BASE + 32'h34, 1'b1);
    @(negedge clk);
    checks++;
    if ({f_gnt, d_gnt} !== 2'b10) begin
      failures++; $display("FAIL ar_first_tie got=%b expected=10", {f_gnt, d_gnt});
    end
    advance(1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if ({f_gnt, d_gnt} !== 2'b01 || {f_err, f_rdata} !== fq[0]) begin
      failures++; $display("FAIL ar_second got gnt=%b f=%h expected gnt=01 f=%h", {f_gnt, d_gnt}, {f_err, f_rdata}, fq[0]);
    end
    advance(1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if ({d_rvalid, d_err, d_rdata} !== {1'b1, dq[0]}) begin
      failures++; $display("FAIL ar_d_resp got v=%b d=%h expected %h", d_rvalid, d_rdata, dq[0]);
    end
    advance(1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'((i * 37 + 11) ^ (i >> 4));
    rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'h00; rom[3] = 8'h00;
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_access_errors();
    test_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
